mem_rr: RTL and testbench

//   Parametrised single-port synchronous RAM with a valid/ready request/response interface.

---
 rtl/mem_rr.sv | 162 ++++++++++++++++
 tb/tb_mem_rr.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rr.sv
// Single-port RAM behind a valid/ready request/response pair: byte-enabled writes, address range
// check and a hardware clear after reset. Optional per-byte even parity when MEM_PARITY_EN is defined.
module mem_rr #(
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 4,
    parameter int unsigned DEPTH = 11,
    localparam int unsigned NB   = DW / 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wr,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [NB-1:0] req_be,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
`ifdef MEM_PARITY_EN
    input  logic          par_inject,
`endif
    output logic          init_done
);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;
    logic          init_done_q, init_done_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic [DW-1:0] mem_q [DEPTH];

    logic          accept;
    logic          in_range;
    logic [DW-1:0] rd_word;
    logic          rd_par_err;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [NB-1:0] mem_wbe;

    assign req_ready = init_done_q && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign in_range  = {1'b0, req_addr} < DEPTH_W;
    assign rd_word   = in_range ? mem_q[req_addr] : '0;

`ifdef MEM_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];
    logic [NB-1:0] rd_par;
    logic [NB-1:0] mem_wpar;

    assign rd_par = in_range ? par_q[req_addr] : '0;

    // Stored parity is compared against the data actually held in each lane.
    always_comb begin
        rd_par_err = 1'b0;
        for (int unsigned b = 0; b < NB; b++) begin
            if (rd_par[b] != ^rd_word[b*8 +: 8]) begin
                rd_par_err = 1'b1;
            end
        end
    end

    // Clear writes parity 0; inject flips the stored bit of every written lane.
    always_comb begin
        mem_wpar = '0;
        if (state_q == ST_RUN) begin
            for (int unsigned b = 0; b < NB; b++) begin
                mem_wpar[b] = (^req_wdata[b*8 +: 8]) ^ par_inject;
            end
        end
    end
`else
    assign rd_par_err = 1'b0;
`endif

    // Next-state, response and memory write-port control.
    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        init_done_d = init_done_q;
        rsp_valid_d = rsp_valid_q && !rsp_ready;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we      = 1'b0;
        mem_waddr   = req_addr;
        mem_wdata   = req_wdata;
        mem_wbe     = req_be;

        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = '0;
                mem_wbe   = '1;
                clr_ptr_d = clr_ptr_q + AW'(1);
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = (!req_wr && in_range) ? rd_word : '0;
                    rsp_err_d   = !in_range || (!req_wr && rd_par_err);
                    mem_we      = req_wr && in_range;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            clr_ptr_q   <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Storage is not reset; the clear sequence zeroes it instead.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (mem_wbe[b]) begin
                    mem_q[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
`ifdef MEM_PARITY_EN
                    par_q[mem_waddr][b] <= mem_wpar[b];
`endif
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_mem_rr.sv
// Directed bench for mem_rr: an 8-bit instance for the main behaviour and a 32-bit one for byte enables.
module tb_mem_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req_valid, req_ready, req_wr;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       req_be;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err, init_done;

    logic        w_req_valid, w_req_ready, w_req_wr;
    logic [3:0]  w_req_addr;
    logic [31:0] w_req_wdata;
    logic [3:0]  w_req_be;
    logic        w_rsp_valid, w_rsp_ready;
    logic [31:0] w_rsp_rdata;
    logic        w_rsp_err, w_init_done;

`ifdef MEM_PARITY_EN
    logic par_inject;
`endif

    mem_rr #(.DW(8), .AW(4), .DEPTH(11)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
`ifdef MEM_PARITY_EN
        .par_inject(par_inject),
`endif
        .init_done (init_done)
    );

    mem_rr #(.DW(32), .AW(4), .DEPTH(11)) u_dut32 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (w_req_valid),
        .req_ready (w_req_ready),
        .req_wr    (w_req_wr),
        .req_addr  (w_req_addr),
        .req_wdata (w_req_wdata),
        .req_be    (w_req_be),
        .rsp_valid (w_rsp_valid),
        .rsp_ready (w_rsp_ready),
        .rsp_rdata (w_rsp_rdata),
        .rsp_err   (w_rsp_err),
`ifdef MEM_PARITY_EN
        .par_inject(par_inject),
`endif
        .init_done (w_init_done)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_mem [11];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One request on the 8-bit instance; response expected one cycle after accept.
    task automatic op(input string tag, input logic wr, input logic [3:0] addr, input logic [7:0] wd,
                      input logic be, input logic [7:0] exp_rd, input logic exp_err);
        int n = 0;
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd; req_be = be; rsp_ready = 1'b1;
        #1;
        while (!req_ready && n < 20) begin @(negedge clk); #1; n++; end
        check({tag, "_rdy"}, 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, "_vld"}, 32'(rsp_valid), 32'h1);
        check({tag, "_data"}, 32'(rsp_rdata), 32'(exp_rd));
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    endtask

    task automatic op32(input string tag, input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err);
        int n = 0;
        w_req_valid = 1'b1; w_req_wr = wr; w_req_addr = addr; w_req_wdata = wd; w_req_be = be;
        w_rsp_ready = 1'b1;
        #1;
        while (!w_req_ready && n < 20) begin @(negedge clk); #1; n++; end
        check({tag, "_rdy"}, 32'(w_req_ready), 32'h1);
        @(negedge clk);
        w_req_valid = 1'b0;
        check({tag, "_vld"}, 32'(w_rsp_valid), 32'h1);
        check({tag, "_data"}, w_rsp_rdata, exp_rd);
        check({tag, "_err"}, 32'(w_rsp_err), 32'(exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_be = 1'b0; rsp_ready = 1'b1;
        w_req_valid = 1'b0; w_req_wr = 1'b0; w_req_addr = '0; w_req_wdata = '0; w_req_be = '0;
        w_rsp_ready = 1'b1;
`ifdef MEM_PARITY_EN
        par_inject = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_vld", 32'(rsp_valid), 32'h0);
        check("rst_data", 32'(rsp_rdata), 32'h0);
        check("rst_err", 32'(rsp_err), 32'h0);
        check("rst_done", 32'(init_done), 32'h0);
        check("rst_rdy", 32'(req_ready), 32'h0);

        // Clear takes exactly 11 cycles with no request accepted.
        rst = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 11; i++) begin
            #1;
            check("clr_done", 32'(init_done), 32'h0);
            check("clr_rdy", 32'(req_ready), 32'h0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("init_done", 32'(init_done), 32'h1);

        for (int i = 0; i < 11; i++) begin
            exp_mem[i] = 8'h00;
            op("init_rd", 1'b0, 4'(i), 8'h00, 1'b0, 8'h00, 1'b0);
        end

        op("wr3", 1'b1, 4'd3, 8'hA5, 1'b1, 8'h00, 1'b0); exp_mem[3] = 8'hA5;
        op("rd3", 1'b0, 4'd3, 8'h00, 1'b0, 8'hA5, 1'b0);
        op("wr7", 1'b1, 4'd7, 8'h96, 1'b1, 8'h00, 1'b0); exp_mem[7] = 8'h96;
        op("rd7", 1'b0, 4'd7, 8'h00, 1'b0, 8'h96, 1'b0);
        op("wr3_be0", 1'b1, 4'd3, 8'h00, 1'b0, 8'h00, 1'b0);
        op("rd3_be0", 1'b0, 4'd3, 8'h00, 1'b0, 8'hA5, 1'b0);
        op("rd11", 1'b0, 4'd11, 8'h00, 1'b0, 8'h00, 1'b1);
        op("rd15", 1'b0, 4'd15, 8'h00, 1'b0, 8'h00, 1'b1);
        op("wr12", 1'b1, 4'd12, 8'hFF, 1'b1, 8'h00, 1'b1);
        for (int i = 0; i < 11; i++) op("scan", 1'b0, 4'(i), 8'h00, 1'b0, exp_mem[i], 1'b0);

        // Backpressure: hold the addr-3 response for 4 cycles while a read of 7 waits.
        req_valid = 1'b0;
        @(negedge clk);
        check("idle_vld", 32'(rsp_valid), 32'h0);
        rsp_ready = 1'b0; req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd3;
        #1 check("bp_rdy_first", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_addr = 4'd7;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_vld", 32'(rsp_valid), 32'h1);
            check("bp_data", 32'(rsp_rdata), 32'hA5);
            check("bp_err", 32'(rsp_err), 32'h0);
            check("bp_rdy", 32'(req_ready), 32'h0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1 check("bp_release_rdy", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_next_vld", 32'(rsp_valid), 32'h1);
        check("bp_next_data", 32'(rsp_rdata), 32'h96);
        @(negedge clk);
        check("bp_drop_vld", 32'(rsp_valid), 32'h0);
        check("bp_hold_data", 32'(rsp_rdata), 32'h96);

        // Streaming: one response per cycle.
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'(i);
            #1 check("strm_rdy", 32'(req_ready), 32'h1);
            @(negedge clk);
            check("strm_vld", 32'(rsp_valid), 32'h1);
            check("strm_data", 32'(rsp_rdata), 32'(exp_mem[i]));
        end
        req_valid = 1'b0;
        @(negedge clk);
        check("strm_end_vld", 32'(rsp_valid), 32'h0);

        // Reset while a write response is pending, then reset again in the middle of clear.
        rsp_ready = 1'b0; req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'd5; req_wdata = 8'h3C; req_be = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_pend_vld", 32'(rsp_valid), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_drop_vld", 32'(rsp_valid), 32'h0);
        rsp_ready = 1'b1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("clr_mid_done", 32'(init_done), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (!init_done && n < 50) begin @(negedge clk); n++; end
        check("clr_len", 32'(n), 32'd11);
        op("rerd5", 1'b0, 4'd5, 8'h00, 1'b0, 8'h00, 1'b0);
        op("rerd3", 1'b0, 4'd3, 8'h00, 1'b0, 8'h00, 1'b0);
        op("rerd7", 1'b0, 4'd7, 8'h00, 1'b0, 8'h00, 1'b0);

        // 32-bit lanes: partial write over an all-ones word.
        op32("w32_ones", 1'b1, 4'd1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0);
        op32("w32_be", 1'b1, 4'd1, 32'h1234_5678, 4'b0101, 32'h0, 1'b0);
        op32("r32", 1'b0, 4'd1, 32'h0, 4'h0, 32'hFF34_FF78, 1'b0);
        op32("w32_hi", 1'b1, 4'd1, 32'hAABB_CCDD, 4'b1000, 32'h0, 1'b0);
        op32("r32_hi", 1'b0, 4'd1, 32'h0, 4'h0, 32'hAA34_FF78, 1'b0);

`ifdef MEM_PARITY_EN
        par_inject = 1'b1;
        op("par_wr", 1'b1, 4'd2, 8'h0F, 1'b1, 8'h00, 1'b0);
        par_inject = 1'b0;
        op("par_rd", 1'b0, 4'd2, 8'h00, 1'b0, 8'h0F, 1'b1);
        op("par_fix", 1'b1, 4'd2, 8'h0F, 1'b1, 8'h00, 1'b0);
        op("par_rd2", 1'b0, 4'd2, 8'h00, 1'b0, 8'h0F, 1'b0);
`endif

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
